comp_weight_loader: RTL
=======================

COMP_WEIGHT_LOADER -- requirements
Module: comp_weight_loader

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ARRAY_SIZE, 8, CPE rows per column and CPE columns driven.
- ADDR_WIDTH, 6, compensation memory address width.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle load request.
- base_addr  in  ADDR_WIDTH  first memory word of the weight tile.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- mem_rd_en  out  1  compensation memory read strobe.
- mem_rd_addr  out  ADDR_WIDTH  read address.
- mem_rd_data  in  4*ARRAY_SIZE  read word, valid exactly 1 cycle after mem_rd_en; one 4-bit weight per column, column 0 in bits [3:0].
- Compensation_Weight  out  4*ARRAY_SIZE  weight bus into the top CPE row.
- Compensation_Weight_out_valid  out  1  weight-shift enable for all CPE columns.

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, FETCH, DRAIN, DONE.
REQ-004 In IDLE, start=1 SHALL latch base_addr, clear row counter k, and enter FETCH next cycle; start in any other state SHALL be ignored.
REQ-005 In FETCH cycle k (0..ARRAY_SIZE-1), the block SHALL assert mem_rd_en with mem_rd_addr = base_addr + ARRAY_SIZE-1-k (bottom row first), modulo 2^ADDR_WIDTH.
REQ-006 After k = ARRAY_SIZE-1 the FSM SHALL enter DRAIN for one cycle, then DONE for one cycle, then IDLE.
REQ-007 Compensation_Weight SHALL equal mem_rd_data unmodified; Compensation_Weight_out_valid SHALL be high in exactly the cycle after each mem_rd_en.
REQ-008 Valid SHALL therefore be high for exactly ARRAY_SIZE consecutive cycles with no gaps, so row r holds word base_addr+r after the burst.
REQ-009 done SHALL be high only in DONE; busy SHALL be high in FETCH, DRAIN, and DONE.
REQ-010 When valid is low, Compensation_Weight SHALL hold its last value; mem_rd_addr SHALL hold its last value when mem_rd_en is low.
REQ-011 Load latency SHALL be: start sampled at edge 0; first valid cycle 2; done in cycle ARRAY_SIZE+2.
REQ-012 start asserted in the same cycle done is high SHALL be ignored; a new load is accepted from IDLE only.

Reset
REQ-013 rst=1 SHALL immediately force IDLE, k=0, busy=0, done=0, mem_rd_en=0, mem_rd_addr=0, Compensation_Weight=0, and Compensation_Weight_out_valid=0, including mid-burst.
REQ-014 After reset release, the first accepted start SHALL perform a complete load; no partial burst resumes.

Configuration
REQ-015 With macro COMP_LOADER_ABORT_EN defined, an input abort (1 bit) SHALL exist.
- abort=1 in FETCH or DRAIN SHALL stop reads that cycle.
- Valid SHALL deassert from the next cycle.
- The FSM SHALL return to IDLE without a done pulse.
- abort SHALL be ignored in IDLE and DONE.
REQ-016 Without COMP_LOADER_ABORT_EN, the abort port and its logic SHALL be absent, and every load SHALL run to done.

Structure
REQ-017 The shared package comp_pkg SHALL hold COMP_WEIGHT_WIDTH=4 and the loader state enum.
REQ-018 No sub-module is required: the FSM, row counter, and one-cycle valid delay register SHALL reside in comp_weight_loader.

Verification
REQ-019 ARRAY_SIZE=4, base_addr=0x10, memory word a = {4{a[3:0]}}, start pulse -> reads at addresses 0x13,0x12,0x11,0x10 in cycles 1-4; valid high in cycles 2-5; done in cycle 6.
REQ-020 base_addr=0x3E, ARRAY_SIZE=4, ADDR_WIDTH=6 -> read addresses 0x01,0x00,0x3F,0x3E (wrap).
REQ-021 start re-pulsed in cycle 3 and again with done high -> no extra reads, one done only; a subsequent start from IDLE is accepted.
REQ-022 rst asserted in cycle 3 of a burst -> valid, mem_rd_en, and busy go low without waiting for a clock edge; the next start yields a full 4-cycle burst.
REQ-023 COMP_LOADER_ABORT_EN defined, abort in cycle 2 -> no reads after cycle 2; valid ends after cycle 3; no done; busy=0 from cycle 3.
REQ-024 Model check: four CPE shift registers fed by the loader -> after done, row r holds weight from word base_addr+r for all r.

Source files
------------

// File: rtl/comp_pkg.sv
// Shared definitions for the compensation weight loader.
//   COMP_WEIGHT_WIDTH : bits per CPE weight (one nibble per column)
//   loader_state_e    : loader FSM state encoding
package comp_pkg;

  localparam int COMP_WEIGHT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } loader_state_e;

endpackage

// File: rtl/comp_weight_loader.sv
// Compensation weight loader.
// Streams an ARRAY_SIZE-word weight tile out of the compensation memory
// into the top CPE row, bottom row first. After the burst row r of every
// CPE column holds the weight from word base_addr+r.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   start, base_addr              load request (accepted in IDLE only) + tile base
//   busy, done                    busy FETCH..DONE, one-cycle done pulse
//   mem_rd_en, mem_rd_addr        memory read strobe / address (data 1 cycle later)
//   mem_rd_data                   read word, column 0 in bits [3:0]
//   Compensation_Weight           weight bus into top CPE row (pass-through + hold)
//   Compensation_Weight_out_valid shift enable for all CPE columns
//   abort                         only with COMP_LOADER_ABORT_EN defined:
//                                 cancels a load in FETCH/DRAIN, no done pulse
module comp_weight_loader
  import comp_pkg::*;
#(
  parameter int ARRAY_SIZE = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [ADDR_WIDTH-1:0]                  base_addr,
`ifdef COMP_LOADER_ABORT_EN
  input  logic                                   abort,
`endif
  output logic                                   busy,
  output logic                                   done,
  output logic                                   mem_rd_en,
  output logic [ADDR_WIDTH-1:0]                  mem_rd_addr,
  input  logic [COMP_WEIGHT_WIDTH*ARRAY_SIZE-1:0] mem_rd_data,
  output logic [COMP_WEIGHT_WIDTH*ARRAY_SIZE-1:0] Compensation_Weight,
  output logic                                   Compensation_Weight_out_valid
);

  localparam int KW = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
  localparam int DW = COMP_WEIGHT_WIDTH * ARRAY_SIZE;
  localparam logic [KW-1:0] K_LAST = KW'(ARRAY_SIZE - 1);

  loader_state_e         state;
  logic [KW-1:0]         k;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [DW-1:0]         cw_hold;

  logic abort_req;
`ifdef COMP_LOADER_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Memory data arrives exactly while valid is high, so the weight bus is a
  // straight pass-through then; otherwise it replays the last word taken.
  assign Compensation_Weight = Compensation_Weight_out_valid ? mem_rd_data : cw_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                         <= IDLE;
      k                             <= '0;
      base_q                        <= '0;
      busy                          <= 1'b0;
      done                          <= 1'b0;
      mem_rd_en                     <= 1'b0;
      mem_rd_addr                   <= '0;
      Compensation_Weight_out_valid <= 1'b0;
      cw_hold                       <= '0;
    end else begin
      // One-cycle valid delay tracks the memory read latency.
      Compensation_Weight_out_valid <= mem_rd_en;
      if (Compensation_Weight_out_valid) cw_hold <= mem_rd_data;
      done <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            base_q      <= base_addr;
            k           <= '0;
            state       <= FETCH;
            busy        <= 1'b1;
            mem_rd_en   <= 1'b1;
            // Bottom row first; address arithmetic wraps modulo 2^ADDR_WIDTH.
            mem_rd_addr <= base_addr + ADDR_WIDTH'(ARRAY_SIZE - 1);
          end
        end
        FETCH: begin
          if (abort_req) begin
            state     <= IDLE;
            k         <= '0;
            busy      <= 1'b0;
            mem_rd_en <= 1'b0;
          end else if (k == K_LAST) begin
            state     <= DRAIN;
            mem_rd_en <= 1'b0;
          end else begin
            k           <= k + 1'b1;
            mem_rd_addr <= base_q + ADDR_WIDTH'(ARRAY_SIZE - 2) - ADDR_WIDTH'(k);
          end
        end
        DRAIN: begin
          if (abort_req) begin
            state <= IDLE;
            k     <= '0;
            busy  <= 1'b0;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          k     <= '0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
